// File: rtl/rs_dec_pkg.sv
// Shared definitions for the RS decoder error-correction stage.
// Holds the codeword geometry, the corrector FSM state type and the
// error-event record produced by the Forney stage.
package rs_dec_pkg;

  localparam int unsigned LANES = 32;          // symbols per beat
  localparam int unsigned W     = 10;          // symbol width
  localparam int unsigned N     = 544;         // codeword length in symbols
  localparam int unsigned T     = 11;          // max correctable errors
  localparam int unsigned POS_W = 10;          // symbol index width
  localparam int unsigned BEATS = N / LANES;   // beats per codeword

  typedef enum logic [1:0] {
    StLoad,
    StFix,
    StEmit
  } state_e;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [W-1:0]     y;
    logic             den_zero;
  } err_evt_t;

endpackage

// File: rtl/rs_err_corrector_if.sv
// Bundle of the corrector's handshake buses: codeword input, Forney error
// events and corrected output. Names are from the corrector's point of view.
//   slave  : used by rs_err_corrector
//   master : used by whoever drives/consumes the corrector
interface rs_err_corrector_if #(
  parameter int unsigned LANES = rs_dec_pkg::LANES,
  parameter int unsigned W     = rs_dec_pkg::W,
  parameter int unsigned POS_W = rs_dec_pkg::POS_W
) ();

  logic                      cw_vld_i;
  logic                      cw_rdy_o;
  logic [LANES-1:0][W-1:0]   cw_data_i;

  logic                      err_vld_i;
  logic                      err_rdy_o;
  logic [POS_W-1:0]          err_pos_i;
  logic [W-1:0]              err_y_i;
  logic                      err_den_zero_i;
  logic                      err_eof_i;

  logic                      out_vld_o;
  logic                      out_rdy_i;
  logic [LANES-1:0][W-1:0]   out_data_o;
  logic                      out_last_o;
  logic                      out_fail_o;
  logic [3:0]                out_err_cnt_o;

  modport slave (
    input  cw_vld_i, cw_data_i,
    input  err_vld_i, err_pos_i, err_y_i, err_den_zero_i, err_eof_i,
    input  out_rdy_i,
    output cw_rdy_o, err_rdy_o,
    output out_vld_o, out_data_o, out_last_o, out_fail_o, out_err_cnt_o
  );

  modport master (
    output cw_vld_i, cw_data_i,
    output err_vld_i, err_pos_i, err_y_i, err_den_zero_i, err_eof_i,
    output out_rdy_i,
    input  cw_rdy_o, err_rdy_o,
    input  out_vld_o, out_data_o, out_last_o, out_fail_o, out_err_cnt_o
  );

endinterface

// File: rtl/rs_sym_buf.sv
// Codeword symbol buffer: BEATS rows of LANES symbols (no reset).
//   clk_i              clock
//   wr_en_i/row/data   whole-row write
//   xor_en_i/pos/val   single-symbol XOR at flat symbol index xor_pos_i
//   rd_row_i/rd_data_o combinational row read
module rs_sym_buf #(
  parameter int unsigned LANES = 32,
  parameter int unsigned W     = 10,
  parameter int unsigned POS_W = 10,
  parameter int unsigned BEATS = 17,
  localparam int unsigned ROW_W  = $clog2(BEATS),
  localparam int unsigned LANE_W = $clog2(LANES)
) (
  input  logic                    clk_i,
  input  logic                    wr_en_i,
  input  logic [ROW_W-1:0]        wr_row_i,
  input  logic [LANES-1:0][W-1:0] wr_data_i,
  input  logic                    xor_en_i,
  input  logic [POS_W-1:0]        xor_pos_i,
  input  logic [W-1:0]            xor_val_i,
  input  logic [ROW_W-1:0]        rd_row_i,
  output logic [LANES-1:0][W-1:0] rd_data_o
);

  logic [LANES-1:0][W-1:0] r_mem [BEATS];
  logic [ROW_W-1:0]        w_xor_row;
  logic [LANE_W-1:0]       w_xor_lane;

  // Caller guarantees xor_pos_i < BEATS*LANES when xor_en_i is set.
  assign w_xor_row  = ROW_W'(32'(xor_pos_i) / LANES);
  assign w_xor_lane = LANE_W'(32'(xor_pos_i) % LANES);

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_row_i] <= wr_data_i;
    end
    if (xor_en_i) begin
      r_mem[w_xor_row][w_xor_lane] <= r_mem[w_xor_row][w_xor_lane] ^ xor_val_i;
    end
  end

  assign rd_data_o = r_mem[rd_row_i];

endmodule

// File: rtl/rs_err_corrector.sv
// RS error corrector: buffers one codeword (LOAD), XORs Forney error
// magnitudes into it (FIX), then streams the corrected codeword out (EMIT).
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   flush_i  synchronous abort back to LOAD
//   bus_if   codeword / error-event / output handshakes (slave side)
module rs_err_corrector
  import rs_dec_pkg::*;
#(
  parameter int unsigned LANES = rs_dec_pkg::LANES,
  parameter int unsigned W     = rs_dec_pkg::W,
  parameter int unsigned N     = rs_dec_pkg::N,
  parameter int unsigned T     = rs_dec_pkg::T,
  parameter int unsigned POS_W = rs_dec_pkg::POS_W,
  parameter int unsigned BEATS = N / LANES
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic               flush_i,
  rs_err_corrector_if.slave bus_if
);

  localparam int unsigned ROW_W = $clog2(BEATS);

  state_e                  r_state, w_state_next;
  logic [ROW_W-1:0]        r_beat_cnt, w_beat_cnt_next;
  logic [3:0]              r_err_cnt, w_err_cnt_next;
  logic                    r_fail, w_fail_next;
  logic                    r_eof_pend, w_eof_pend_next;
  logic                    r_rdy_en;  // holds readies low until first clock after reset
  err_evt_t                w_evt;
  logic                    w_evt_bad, w_last;
  logic                    w_cw_rdy, w_err_rdy, w_out_vld;
  logic                    w_wr_en, w_xor_en;
  logic [LANES-1:0][W-1:0] w_rd_data;

  assign w_evt = '{pos: bus_if.err_pos_i, y: bus_if.err_y_i, den_zero: bus_if.err_den_zero_i};
  assign w_last = (r_beat_cnt == ROW_W'(BEATS - 1));
  assign w_evt_bad = w_evt.den_zero || (32'(w_evt.pos) >= N) || (32'(r_err_cnt) == T);

  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    w_err_cnt_next  = r_err_cnt;
    w_fail_next     = r_fail;
    w_eof_pend_next = r_eof_pend;
    w_cw_rdy        = 1'b0;
    w_err_rdy       = 1'b0;
    w_out_vld       = 1'b0;
    w_wr_en         = 1'b0;
    w_xor_en        = 1'b0;

    unique case (r_state)
      StLoad: begin
        w_cw_rdy = r_rdy_en && !flush_i;
        if (bus_if.err_eof_i) w_eof_pend_next = 1'b1;
        if (bus_if.cw_vld_i && w_cw_rdy) begin
          w_wr_en = 1'b1;
          if (w_last) begin
            w_beat_cnt_next = '0;
            w_state_next    = StFix;
          end else begin
            w_beat_cnt_next = r_beat_cnt + 1'b1;
          end
        end
      end
      StFix: begin
        w_err_rdy = !flush_i;
        if (bus_if.err_vld_i && w_err_rdy) begin
          if (w_evt_bad) begin
            w_fail_next = 1'b1;
          end else begin
            w_xor_en       = 1'b1;
            w_err_cnt_next = r_err_cnt + 1'b1;
          end
        end
        // An eof latched during LOAD counts as seen on the first FIX cycle.
        if (bus_if.err_eof_i || r_eof_pend) begin
          w_state_next    = StEmit;
          w_eof_pend_next = 1'b0;
        end
      end
      StEmit: begin
        w_out_vld = 1'b1;
        if (bus_if.out_rdy_i) begin
          if (w_last) begin
            w_state_next    = StLoad;
            w_beat_cnt_next = '0;
            w_err_cnt_next  = '0;
            w_fail_next     = 1'b0;
          end else begin
            w_beat_cnt_next = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = StLoad;
    endcase

    if (flush_i) begin
      w_state_next    = StLoad;
      w_beat_cnt_next = '0;
      w_err_cnt_next  = '0;
      w_fail_next     = 1'b0;
      w_eof_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StLoad;
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
      r_fail     <= 1'b0;
      r_eof_pend <= 1'b0;
      r_rdy_en   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_err_cnt  <= w_err_cnt_next;
      r_fail     <= w_fail_next;
      r_eof_pend <= w_eof_pend_next;
      r_rdy_en   <= 1'b1;
    end
  end

  rs_sym_buf #(
    .LANES (LANES),
    .W     (W),
    .POS_W (POS_W),
    .BEATS (BEATS)
  ) u_sym_buf (
    .clk_i     (clk_i),
    .wr_en_i   (w_wr_en),
    .wr_row_i  (r_beat_cnt),
    .wr_data_i (bus_if.cw_data_i),
    .xor_en_i  (w_xor_en),
    .xor_pos_i (w_evt.pos),
    .xor_val_i (w_evt.y),
    .rd_row_i  (r_beat_cnt),
    .rd_data_o (w_rd_data)
  );

  assign bus_if.cw_rdy_o      = w_cw_rdy;
  assign bus_if.err_rdy_o     = w_err_rdy;
  assign bus_if.out_vld_o     = w_out_vld;
  assign bus_if.out_data_o    = w_rd_data;
  assign bus_if.out_last_o    = w_out_vld && w_last;
  assign bus_if.out_fail_o    = r_fail;
  assign bus_if.out_err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_rs_err_corrector.sv
// Directed + randomized bench for rs_err_corrector with a symbol-array model.
module tb_rs_err_corrector;
  import rs_dec_pkg::*;

  localparam int unsigned RW = LANES * W;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic flush_i;

  always #5 clk_i = ~clk_i;

  rs_err_corrector_if bus ();

  rs_err_corrector dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus_if  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] in_mem  [N];
  logic [W-1:0] ref_mem [N];
  logic [W-1:0] cap     [N];
  int           ref_cnt;
  bit           ref_fail;
  logic         cap_fail;
  logic [3:0]   cap_cnt;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] in_row(input int b);
    logic [RW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*W +: W] = in_mem[b*LANES+k];
    return r;
  endfunction

  function automatic logic [RW-1:0] ref_row(input int b);
    logic [RW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*W +: W] = ref_mem[b*LANES+k];
    return r;
  endfunction

  // kind 0: sym[i] = i, otherwise random symbols
  task automatic new_frame(input int kind);
    for (int i = 0; i < N; i++) begin
      in_mem[i] = (kind == 0) ? W'(i) : W'($urandom_range(0, (1 << W) - 1));
      ref_mem[i] = in_mem[i];
    end
    ref_cnt  = 0;
    ref_fail = 1'b0;
  endtask

  // eof_beat >= 0 pulses err_eof_i alongside that load beat
  task automatic load_frame(input int eof_beat);
    int w;
    for (int b = 0; b < BEATS; b++) begin
      bus.cw_data_i = in_row(b);
      bus.cw_vld_i  = 1'b1;
      bus.err_eof_i = (b == eof_beat);
      for (w = 0; w < 50; w++) begin
        @(negedge clk_i);
        if (bus.cw_rdy_o === 1'b1) break;
      end
      if (w == 50) chk("cw_rdy_timeout", bus.cw_rdy_o, 1);
      @(posedge clk_i); #1;
      bus.cw_vld_i  = 1'b0;
      bus.err_eof_i = 1'b0;
    end
  endtask

  task automatic send_evt(input int pos, input logic [W-1:0] y, input bit dz, input bit eof);
    int w;
    bus.err_pos_i      = POS_W'(pos);
    bus.err_y_i        = y;
    bus.err_den_zero_i = dz;
    bus.err_eof_i      = eof;
    bus.err_vld_i      = 1'b1;
    for (w = 0; w < 50; w++) begin
      @(negedge clk_i);
      if (bus.err_rdy_o === 1'b1) break;
    end
    if (w == 50) chk("err_rdy_timeout", bus.err_rdy_o, 1);
    @(posedge clk_i); #1;
    bus.err_vld_i = 1'b0;
    bus.err_eof_i = 1'b0;
    // Reference rules: bad events only flag failure; good ones correct the symbol.
    if (dz || pos >= int'(N) || ref_cnt == int'(T)) begin
      ref_fail = 1'b1;
    end else begin
      ref_mem[pos] = ref_mem[pos] ^ y;
      ref_cnt++;
    end
  endtask

  task automatic pulse_eof();
    bus.err_eof_i = 1'b1;
    @(posedge clk_i); #1;
    bus.err_eof_i = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle 1/0, 2: random. imm: first cycle must be valid.
  task automatic collect(input int mode, input bit imm, input string tag);
    int beat = 0;
    for (int cyc = 0; cyc < 400 && beat < int'(BEATS); cyc++) begin
      case (mode)
        0:       bus.out_rdy_i = 1'b1;
        1:       bus.out_rdy_i = (cyc % 2 == 0);
        default: bus.out_rdy_i = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk_i);
      if (cyc == 0 && imm) chk({tag, "_latency"}, bus.out_vld_o, 1);
      if (bus.out_vld_o === 1'b1) begin
        chk({tag, "_data"}, bus.out_data_o, ref_row(beat));
        chk({tag, "_last"}, bus.out_last_o, (beat == int'(BEATS) - 1));
        chk({tag, "_fail"}, bus.out_fail_o, ref_fail);
        chk({tag, "_cnt"}, bus.out_err_cnt_o, ref_cnt);
        if (bus.out_rdy_i) begin
          for (int k = 0; k < LANES; k++) cap[beat*LANES+k] = bus.out_data_o[k];
          cap_fail = bus.out_fail_o;
          cap_cnt  = bus.out_err_cnt_o;
          beat++;
        end
      end
      @(posedge clk_i); #1;
    end
    bus.out_rdy_i = 1'b0;
    chk({tag, "_beats"}, beat, BEATS);
    @(negedge clk_i);
    chk({tag, "_back_to_load"}, {bus.out_vld_o, bus.cw_rdy_o}, 2'b01);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p12;
    int prev_pos;
    int nev;
    logic [W-1:0] y;

    rst_ni             = 1'b1;
    flush_i            = 1'b0;
    bus.cw_vld_i       = 1'b0;
    bus.cw_data_i      = '0;
    bus.err_vld_i      = 1'b0;
    bus.err_pos_i      = '0;
    bus.err_y_i        = '0;
    bus.err_den_zero_i = 1'b0;
    bus.err_eof_i      = 1'b0;
    bus.out_rdy_i      = 1'b0;

    // Reset: readies and valid low; cw_rdy rises on first clock after release.
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_rdys_vld", {bus.cw_rdy_o, bus.err_rdy_o, bus.out_vld_o}, 3'b000);
    #20 rst_ni = 1'b1;
    #1;
    chk("rst_release_cw_rdy", bus.cw_rdy_o, 0);
    @(posedge clk_i); #1;
    chk("first_clk_cw_rdy", {bus.cw_rdy_o, bus.err_rdy_o, bus.out_vld_o}, 3'b100);

    // Two corrections on a ramp codeword.
    new_frame(0);
    load_frame(-1);
    @(negedge clk_i);
    chk("fix_rdys", {bus.cw_rdy_o, bus.err_rdy_o, bus.out_vld_o}, 3'b010);
    @(posedge clk_i); #1;
    send_evt(5, 10'h3FF, 1'b0, 1'b0);
    send_evt(543, 10'h001, 1'b0, 1'b0);
    pulse_eof();
    collect(0, 1'b1, "ramp2");
    chk("ramp2_sym5", cap[5], 10'h3FA);
    chk("ramp2_sym543", cap[543], 10'h21E);
    chk("ramp2_cnt", cap_cnt, 2);
    chk("ramp2_fail", cap_fail, 0);

    // Zero Forney denominator: no correction, frame fails.
    new_frame(0);
    load_frame(-1);
    send_evt(7, 10'h155, 1'b1, 1'b0);
    pulse_eof();
    collect(2, 1'b1, "denzero");
    chk("denzero_sym7", cap[7], 10'd7);
    chk("denzero_fail", cap_fail, 1);
    chk("denzero_cnt", cap_cnt, 0);

    // Twelve valid events: only T applied, the last one fails the frame.
    new_frame(1);
    load_frame(-1);
    p12 = 11 * 40 + 3;
    for (int i = 0; i < 12; i++) begin
      send_evt(i * 40 + 3, W'($urandom_range(1, (1 << W) - 1)), 1'b0, (i == 11));
    end
    collect(0, 1'b1, "over_t");
    chk("over_t_cnt", cap_cnt, 11);
    chk("over_t_fail", cap_fail, 1);
    chk("over_t_12th_untouched", cap[p12], in_mem[p12]);

    // eof during LOAD beat 3, no events: one FIX cycle then EMIT, data unchanged.
    new_frame(1);
    load_frame(3);
    @(negedge clk_i);
    chk("eofpend_fix_cycle", {bus.out_vld_o, bus.err_rdy_o}, 2'b01);
    @(posedge clk_i); #1;
    collect(0, 1'b1, "eofpend");
    for (int b = 0; b < BEATS; b++) begin
      logic [RW-1:0] r;
      for (int k = 0; k < LANES; k++) r[k*W +: W] = cap[b*LANES+k];
      chk("eofpend_unchanged", r, in_row(b));
    end

    // Output back-pressure toggling every cycle.
    new_frame(1);
    load_frame(-1);
    send_evt(200, 10'h2A5, 1'b0, 1'b1);
    collect(1, 1'b1, "toggle");

    // Flush in FIX after two events, then a clean frame.
    new_frame(1);
    load_frame(-1);
    send_evt(10, 10'h011, 1'b0, 1'b0);
    send_evt(20, 10'h022, 1'b0, 1'b0);
    flush_i       = 1'b1;
    bus.err_vld_i = 1'b1;
    @(negedge clk_i);
    chk("flush_rdys_low", {bus.cw_rdy_o, bus.err_rdy_o}, 2'b00);
    @(posedge clk_i); #1;
    flush_i       = 1'b0;
    bus.err_vld_i = 1'b0;
    @(negedge clk_i);
    chk("flush_to_load", {bus.cw_rdy_o, bus.err_rdy_o, bus.out_vld_o}, 3'b100);
    @(posedge clk_i); #1;
    new_frame(1);
    load_frame(-1);
    pulse_eof();
    collect(0, 1'b1, "postflush");
    chk("postflush_cnt", cap_cnt, 0);
    chk("postflush_fail", cap_fail, 0);

    // Reset mid-EMIT: valid drops at once and the frame is discarded.
    new_frame(1);
    load_frame(-1);
    send_evt(33, 10'h0F0, 1'b0, 1'b1);
    bus.out_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("pre_rst_vld", bus.out_vld_o, 1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("midemit_rst", {bus.out_vld_o, bus.cw_rdy_o, bus.err_rdy_o}, 3'b000);
    #1 rst_ni = 1'b1;
    bus.out_rdy_i = 1'b0;
    #1;
    chk("midemit_release_cw_rdy", bus.cw_rdy_o, 0);
    @(posedge clk_i); #1;
    chk("midemit_after_clk", {bus.cw_rdy_o, bus.out_vld_o}, 2'b10);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      new_frame(1);
      if ($urandom_range(0, 3) == 0) begin
        load_frame($urandom_range(0, BEATS - 1));
        @(negedge clk_i);
        chk("rnd_eofpend_fix", bus.out_vld_o, 0);
        @(posedge clk_i); #1;
      end else begin
        load_frame(-1);
        nev      = $urandom_range(0, 13);
        prev_pos = 0;
        for (int e = 0; e < nev; e++) begin
          int r;
          int pos;
          r = $urandom_range(0, 9);
          if (r == 0) pos = $urandom_range(N, (1 << POS_W) - 1);
          else if (r == 1) pos = prev_pos;
          else pos = $urandom_range(0, N - 1);
          prev_pos = pos;
          y = W'($urandom_range(1, (1 << W) - 1));
          send_evt(pos, y, ($urandom_range(0, 9) == 0), (e == nev - 1) && (f % 2 == 0));
        end
        if (nev == 0 || f % 2 != 0) pulse_eof();
      end
      collect(2, 1'b1, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_err_corrector.md
RS_ERR_CORRECTOR -- requirements
Module: rs_err_corrector

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- LANES, 32, symbols per beat.
- W, 10, symbol width.
- N, 544, codeword length in symbols.
- T, 11, max correctable errors.
- POS_W, 10, position width.
- BEATS = N/LANES (17), derived.
REQ-002 Ports (name direction width meaning) SHALL be:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort; returns to LOAD.
- cw_vld_i  in  1  codeword beat valid.
- cw_rdy_o  out  1  codeword beat ready.
- cw_data_i  in  LANES x W  symbols; lane k = index beat*LANES+k.
- err_vld_i  in  1  error event valid (Forney output).
- err_rdy_o  out  1  error event ready.
- err_pos_i  in  POS_W  symbol index.
- err_y_i  in  W  error magnitude.
- err_den_zero_i  in  1  Forney denominator was zero.
- err_eof_i  in  1  one-cycle pulse: no further events for this frame.
- out_vld_o  out  1  corrected beat valid.
- out_rdy_i  in  1  downstream ready.
- out_data_o  out  LANES x W  corrected symbols.
- out_last_o  out  1  marks beat BEATS-1.
- out_fail_o  out  1  frame uncorrectable; valid on every output beat.
- out_err_cnt_o  out  4  applied error count; valid on every output beat.

Function
REQ-003 FSM SHALL have exactly three states: LOAD, FIX, EMIT.
REQ-004 LOAD:
- cw_rdy_o=1; err_rdy_o=0; out_vld_o=0.
- Each cw handshake writes LANES symbols to buffer row beat_cnt; beat_cnt increments.
- Handshake at beat_cnt=BEATS-1: clear beat_cnt, enter FIX next cycle.
REQ-005 FIX:
- err_rdy_o=1; cw_rdy_o=0.
- Each err handshake performs buf[err_pos_i] ^= err_y_i in that same cycle, and increments err_cnt.
REQ-006 In FIX, the event SHALL NOT modify the buffer and SHALL set fail if any of: err_den_zero_i=1; err_pos_i>=N; err_cnt already equals T.
REQ-007 err_eof_i SHALL be honored as follows:
- Seen in FIX: EMIT next cycle.
- Seen in LOAD: latched in eof_pend; consumed on FIX entry, giving FIX then EMIT on the following cycle.
- Coincident with an err handshake: the event is applied first.
REQ-008 EMIT:
- out_vld_o=1; out_data_o = buffer row beat_cnt (combinational mux).
- out_last_o = (beat_cnt==BEATS-1).
- Row advances only on out_vld_o&&out_rdy_i; data held stable while stalled.
- Last handshake: return to LOAD, clear err_cnt, fail and beat_cnt.
REQ-009 Latency: eof in FIX at cycle m -> first out_vld_o at m+1; a zero-error frame SHALL be emitted unchanged.
REQ-010 flush_i SHALL take priority over all handshakes:
- Next state LOAD; clear beat_cnt, err_cnt, fail, eof_pend.
- Buffer contents are don't-care.
- Ready outputs are forced 0 in the flush cycle.
REQ-011 A duplicate pos SHALL XOR twice; no check is made.
REQ-012 err_cnt SHALL saturate at T.

Reset
REQ-013 rst_ni low SHALL asynchronously force:
- state=LOAD; beat_cnt=0, err_cnt=0, fail=0, eof_pend=0.
- out_vld_o=0, err_rdy_o=0, cw_rdy_o=0.
- cw_rdy_o rises on the first clock after release.
REQ-014 The buffer SHALL NOT be reset.
REQ-015 Reset asserted mid-frame SHALL discard the frame with no output.

Structure
REQ-016 A shared package rs_dec_pkg SHALL hold: the state enum, N, T, W, POS_W, LANES, BEATS, and an err_evt_t struct {pos, y, den_zero}.
REQ-017 One sub-module, rs_sym_buf, SHALL contain:
- N x W flop array.
- Row write port (LANES wide).
- Single-symbol XOR port.
- Row read mux.
Pos decode into row/lane (pos/LANES, pos%LANES) SHALL be implemented inside rs_sym_buf.

Verification
REQ-018 Load codeword sym[i]=i; send events (pos 5, y 0x3FF), (pos 543, y 0x001); then eof -> out beat0 lane5 = 0x3FA, beat16 lane31 = 0x21E; out_err_cnt_o=2; out_fail_o=0.
REQ-019 Event with err_den_zero_i=1 at pos 7 -> symbol 7 unchanged; out_fail_o=1; out_err_cnt_o=0.
REQ-020 12 valid events -> first 11 applied; 12th not applied; out_fail_o=1; out_err_cnt_o=11.
REQ-021 err_eof_i pulsed during LOAD beat 3; no events -> EMIT one cycle after FIX entry; all 17 beats identical to input.
REQ-022 out_rdy_i toggling 1/0 every cycle during EMIT -> 17 beats in order; data stable while stalled; out_last_o only on beat 16.
REQ-023 flush_i asserted in FIX after 2 events -> LOAD next cycle; following frame emits with out_err_cnt_o=0 and out_fail_o=0; rst_ni asserted mid-EMIT -> out_vld_o=0 immediately.
